// File: rtl/hazard_controller.sv
// ============================================================================
// Module   : hazard_controller
// Brief    : OTTER RV32I hazard/stall controller with EX/MEM/WB scoreboard,
//            operand forwarding selects and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller (
  input  logic        REG_CLOCK,
  input  logic        REG_RESET,
  input  logic [31:0] FR_MEM,
  input  logic        ID_REGWRITE,
  input  logic        ID_MEMWRITE,
  input  logic        ID_MEMREAD_2,
  input  logic        BR_TAKEN,
  input  logic        MEM_READY,
  output logic        PC_WRITE,
  output logic        FR_WRITE,
  output logic        FR_FLUSH,
  output logic        DEC_BUBBLE,
  output logic        DEC_HOLD,
  output logic [1:0]  FWD_A_SEL,
  output logic [1:0]  FWD_B_SEL,
  output logic [1:0]  HAZ_STATE,
  output logic [15:0] STALL_COUNT,
  output logic [15:0] FLUSH_COUNT
);

  localparam logic [1:0] c_st_run    = 2'b00;
  localparam logic [1:0] c_st_lstall = 2'b01;
  localparam logic [1:0] c_st_flush  = 2'b10;
  localparam logic [1:0] c_st_mwait  = 2'b11;

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       st;
  } sb_t;

  sb_t         r_sb_ex, r_sb_mem, r_sb_wb;
  logic [1:0]  r_haz_state;
  logic [15:0] r_stall_cnt, r_flush_cnt;

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [6:0]  w_op;
  logic        w_use_rs1, w_use_rs2;
  logic        w_mem_wait, w_ld_use;
  logic [1:0]  w_action;
  logic        w_bubble;
  logic        w_unused;

  assign w_rs1    = FR_MEM[19:15];
  assign w_rs2    = FR_MEM[24:20];
  assign w_rd     = FR_MEM[11:7];
  assign w_op     = FR_MEM[6:0];
  assign w_unused = ^{FR_MEM[31:25], FR_MEM[14:12]};

  assign w_use_rs1 = !((w_op == c_op_lui) || (w_op == c_op_auipc) || (w_op == c_op_jal));
  assign w_use_rs2 = (w_op == c_op_rtype) || (w_op == c_op_store) || (w_op == c_op_branch);

  function automatic logic f_match(input sb_t e, input logic [4:0] r, input logic used);
    return used && e.v && e.rw && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward yet.
  function automatic logic [1:0] f_fwd(input logic [4:0] r, input logic used);
    if (f_match(r_sb_ex, r, used))       return r_sb_ex.ld ? 2'b00 : 2'b01;
    else if (f_match(r_sb_mem, r, used)) return 2'b10;
    else if (f_match(r_sb_wb, r, used))  return 2'b11;
    else                                 return 2'b00;
  endfunction

  assign w_mem_wait = r_sb_mem.v && (r_sb_mem.ld || r_sb_mem.st) && !MEM_READY;
  assign w_ld_use   = r_sb_ex.v && r_sb_ex.ld &&
                      (f_match(r_sb_ex, w_rs1, w_use_rs1) || f_match(r_sb_ex, w_rs2, w_use_rs2));

  always_comb begin
    if (w_mem_wait)    w_action = c_st_mwait;
    else if (BR_TAKEN) w_action = c_st_flush;
    else if (w_ld_use) w_action = c_st_lstall;
    else               w_action = c_st_run;
  end

  assign w_bubble = (w_action == c_st_flush) || (w_action == c_st_lstall);

  always_comb begin
    PC_WRITE   = 1'b1;
    FR_WRITE   = 1'b1;
    FR_FLUSH   = 1'b0;
    DEC_BUBBLE = 1'b0;
    DEC_HOLD   = 1'b0;
    FWD_A_SEL  = f_fwd(w_rs1, w_use_rs1);
    FWD_B_SEL  = f_fwd(w_rs2, w_use_rs2);
    case (w_action)
      c_st_mwait: begin
        PC_WRITE = 1'b0;
        FR_WRITE = 1'b0;
        DEC_HOLD = 1'b1;
      end
      c_st_flush: begin
        FR_FLUSH   = 1'b1;
        DEC_BUBBLE = 1'b1;
      end
      c_st_lstall: begin
        PC_WRITE   = 1'b0;
        FR_WRITE   = 1'b0;
        DEC_BUBBLE = 1'b1;
      end
      default: ;
    endcase
    // Reset flushes the front end regardless of any pending hazard.
    if (REG_RESET) begin
      PC_WRITE   = 1'b1;
      FR_WRITE   = 1'b1;
      FR_FLUSH   = 1'b1;
      DEC_BUBBLE = 1'b1;
      DEC_HOLD   = 1'b0;
      FWD_A_SEL  = 2'b00;
      FWD_B_SEL  = 2'b00;
    end
  end

  always_ff @(posedge REG_CLOCK) begin
    if (REG_RESET) begin
      r_sb_ex     <= '0;
      r_sb_mem    <= '0;
      r_sb_wb     <= '0;
      r_haz_state <= c_st_run;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_haz_state <= w_action;
      if (w_action != c_st_mwait) begin
        r_sb_wb  <= r_sb_mem;
        r_sb_mem <= r_sb_ex;
        r_sb_ex  <= w_bubble ? '0 : {1'b1, w_rd, ID_REGWRITE, ID_MEMREAD_2, ID_MEMWRITE};
      end
      if (((w_action == c_st_lstall) || (w_action == c_st_mwait)) && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if ((w_action == c_st_flush) && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign HAZ_STATE   = r_haz_state;
  assign STALL_COUNT = r_stall_cnt;
  assign FLUSH_COUNT = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Self-checking bench for hazard_controller against an in-flight
//            instruction model, with directed and randomized instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fr;
  logic        id_rw, id_mw, id_mr, br, mrdy;
  logic        pc_we, fr_we, fr_fl, bub, hold;
  logic [1:0]  fa, fb, hs;
  logic [15:0] sc, fc;

  always #5 clk = ~clk;

  hazard_controller dut (
    .REG_CLOCK(clk), .REG_RESET(rst), .FR_MEM(fr),
    .ID_REGWRITE(id_rw), .ID_MEMWRITE(id_mw), .ID_MEMREAD_2(id_mr),
    .BR_TAKEN(br), .MEM_READY(mrdy),
    .PC_WRITE(pc_we), .FR_WRITE(fr_we), .FR_FLUSH(fr_fl), .DEC_BUBBLE(bub),
    .DEC_HOLD(hold), .FWD_A_SEL(fa), .FWD_B_SEL(fb), .HAZ_STATE(hs),
    .STALL_COUNT(sc), .FLUSH_COUNT(fc)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // In-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit       st;
  } inst_t;

  inst_t m [3];
  int    m_state, m_stall, m_flush;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input bit [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction

  function automatic bit reads_rs2(input bit [6:0] op);
    return op == 7'h33 || op == 7'h23 || op == 7'h63;
  endfunction

  function automatic bit writes(input inst_t e, input bit [4:0] r);
    return e.v && e.rw && e.rd != 0 && e.rd == r;
  endfunction

  function automatic bit depends_on(input inst_t e);
    return (reads_rs1(fr[6:0]) && writes(e, fr[19:15])) ||
           (reads_rs2(fr[6:0]) && writes(e, fr[24:20]));
  endfunction

  // 0 run, 1 load stall, 2 flush, 3 memory wait
  function automatic int model_action();
    if (m[1].v && (m[1].ld || m[1].st) && !mrdy) return 3;
    if (br) return 2;
    if (m[0].v && m[0].ld && depends_on(m[0])) return 1;
    return 0;
  endfunction

  function automatic int model_fwd(input bit [4:0] r, input bit used);
    if (!used) return 0;
    for (int i = 0; i < 3; i++)
      if (writes(m[i], r)) return (i == 0 && m[i].ld) ? 0 : i + 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m[0] <= '0; m[1] <= '0; m[2] <= '0;
      m_state <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (model_action() != 3) begin
        m[2] <= m[1];
        m[1] <= m[0];
        m[0] <= (model_action() == 1 || model_action() == 2) ? inst_t'(0)
                : inst_t'({1'b1, fr[11:7], id_rw, id_mr, id_mw});
      end
      m_state <= model_action();
      if ((model_action() == 1 || model_action() == 3) && m_stall < 65535) m_stall <= m_stall + 1;
      if (model_action() == 2 && m_flush < 65535) m_flush <= m_flush + 1;
    end
  end

  // {PC_WRITE, FR_WRITE, FR_FLUSH, DEC_BUBBLE, DEC_HOLD} per action; index 4 = reset
  logic [4:0] ctl_tab [5] = '{5'b11000, 5'b00010, 5'b11110, 5'b00001, 5'b11110};

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      int a;
      a = rst ? 4 : model_action();
      cmp("ctl", {pc_we, fr_we, fr_fl, bub, hold}, ctl_tab[a]);
      cmp("fwd_a", fa, rst ? 0 : model_fwd(fr[19:15], reads_rs1(fr[6:0])));
      cmp("fwd_b", fb, rst ? 0 : model_fwd(fr[24:20], reads_rs2(fr[6:0])));
      cmp("haz_state", hs, m_state);
      cmp("stall_count", sc, m_stall);
      cmp("flush_count", fc, m_flush);
    end
  end

  task automatic cyc(input logic [31:0] i, input bit rw, input bit mr, input bit mw,
                     input bit b, input bit rdy, input bit r);
    @(negedge clk);
    fr = i; id_rw = rw; id_mr = mr; id_mw = mw; br = b; mrdy = rdy; rst = r;
    #3;
  endtask

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] LW3   = 32'h0000A183; // lw  x3,0(x1)
  localparam logic [31:0] ADD4  = 32'h00218233; // add x4,x3,x2
  localparam logic [31:0] SW3   = 32'h0030A023; // sw  x3,0(x1)

  bit [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  initial begin
    fr = 0; id_rw = 0; id_mr = 0; id_mw = 0; br = 0; mrdy = 0; rst = 1;
    chk_en = 1'b1;

    // Reset held two cycles, then released with all inputs low
    cyc(0, 0, 0, 0, 0, 0, 1);
    cmp("rst_flush", fr_fl, 1); cmp("rst_bubble", bub, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cmp("post_rst_state", hs, 0); cmp("post_rst_stall", sc, 0);
    cmp("post_rst_fwd", {fa, fb}, 0);

    // Forwarding priority
    cyc(32'h00100293, 1, 0, 0, 0, 1, 0);             // addi x5,x0,1
    cyc(32'h00228293, 1, 0, 0, 0, 1, 0);             // addi x5,x5,2
    cmp("fwd_ex_a", fa, 2'b01);
    cyc(32'h00528333, 1, 0, 0, 0, 1, 0);             // add x6,x5,x5
    cmp("fwd_ex_prio_a", fa, 2'b01); cmp("fwd_ex_prio_b", fb, 2'b01);
    cyc(32'h00500013, 1, 0, 0, 0, 1, 0);             // addi x0,x0,5
    cyc(32'h000003B3, 1, 0, 0, 0, 1, 0);             // add x7,x0,x0
    cmp("fwd_x0", {fa, fb}, 0);

    // Load-use
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(ADD4, 1, 0, 0, 0, 1, 0);
    cmp("lu_pc", pc_we, 0); cmp("lu_bubble", bub, 1);
    cyc(ADD4, 1, 0, 0, 0, 1, 0);
    cmp("lu_release_pc", pc_we, 1); cmp("lu_fwd_mem", fa, 2'b10);
    cmp("lu_state", hs, 1); cmp("lu_stall_cnt", sc, 1);
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(SW3, 0, 0, 1, 0, 1, 0);
    cmp("lu_store_pc", pc_we, 0);
    cyc(SW3, 0, 0, 1, 0, 1, 0);
    cmp("lu_store_cnt", sc, 2);

    // Branch beats load-use stall
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(ADD4, 1, 0, 0, 1, 1, 0);
    cmp("br_flush", fr_fl, 1); cmp("br_pc", pc_we, 1);
    cyc(NOP, 0, 0, 0, 0, 1, 0);
    cmp("br_state", hs, 2'b10); cmp("br_flush_cnt", fc, 1); cmp("br_stall_cnt", sc, 2);

    // Memory wait with a masked branch in the middle
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 0, 1, 0);
    cyc(ADD4, 1, 0, 0, 0, 0, 0);
    cmp("mw_hold1", hold, 1); cmp("mw_fwd1", fa, 2'b10);
    cyc(ADD4, 1, 0, 0, 1, 0, 0);
    cmp("mw_hold2", hold, 1); cmp("mw_noflush", fr_fl, 0); cmp("mw_fwd2", fa, 2'b10);
    cyc(ADD4, 1, 0, 0, 0, 0, 0);
    cmp("mw_hold3", hold, 1); cmp("mw_fwd3", fa, 2'b10);
    cyc(ADD4, 1, 0, 0, 0, 1, 0);
    cmp("mw_stall_cnt", sc, 5); cmp("mw_state", hs, 2'b11); cmp("mw_flush_cnt", fc, 1);

    // Reset during a memory wait
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 0, 0, 0);
    cmp("mwr_hold", hold, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 1);
    cmp("mwr_rst_hold", hold, 0); cmp("mwr_rst_flush", fr_fl, 1);
    cyc(NOP, 0, 0, 0, 0, 0, 0);
    cmp("mwr_state", hs, 0); cmp("mwr_cnts", {sc, fc}, 0); cmp("mwr_nohold", hold, 0);

    // Randomized instruction stream
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      bit [6:0] op;
      bit rw;
      op  = ops[$urandom_range(0, 8)];
      ins = $urandom;
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      rw = !(op == 7'h23 || op == 7'h63);
      if ($urandom_range(0, 7) == 0) rw = !rw;
      cyc(ins, rw, op == 7'h03, op == 7'h23, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    // Stall counter saturation through a long memory wait
    cyc(NOP, 0, 0, 0, 0, 1, 1);
    cyc(LW3, 1, 1, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 0, 1, 0);
    repeat (65540) cyc(NOP, 0, 0, 0, 0, 0, 0);
    cmp("sat_stall", sc, 16'hFFFF);
    cyc(NOP, 0, 0, 0, 0, 0, 0);
    cmp("sat_hold", sc, 16'hFFFF);
    cyc(NOP, 0, 0, 0, 0, 1, 0);
    cmp("sat_hold2", sc, 16'hFFFF);

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
